gpu_rect_span_sequencer: RTL and testbench
==========================================

Name: gpu_rect_span_sequencer

Overview:
- Command-level front end for the GPU write path.
- Accepts one rectangle-fill command (x, y, w, h, colour) and clips it to the display.
- Splits the rectangle into one horizontal span per row and issues each span to the downstream span-write controller over the xpos/ypos/len/enable/busy handshake.
- Presents the fill colour as write data for every word the controller strobes into the SDRAM write path.

Parameters:
- H_DISP, 1024, display width in pixels (words per line).
- V_DISP, 600, display height in lines.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_x  in  16  left column.
- cmd_y  in  16  top row.
- cmd_w  in  16  width in pixels.
- cmd_h  in  16  height in rows.
- cmd_color  in  32  fill word.
- xpos  out  16  span start column to controller.
- ypos  out  16  span row to controller.
- len  out  24  span length in words to controller.
- enable  out  1  span request to controller.
- busy  in  1  controller busy.
- sys_write_enable  in  1  controller write strobe (observed, not driven).
- sys_write_data  out  32  write word; equals latched colour.
- done  out  1  one-cycle pulse when the last span completes.
- cmd_err  out  1  one-cycle pulse when a command is rejected.
- pix_count  out  24  write strobes counted for the current command; cleared on accept.

Behaviour:
- Reset (sync, rst=1): state IDLE.
  - Outputs after reset: cmd_ready=1, enable=0, done=0, cmd_err=0, xpos=ypos=0, len=0, sys_write_data=0, pix_count=0.
  - Row counter is cleared.
  - Reset mid-span drops enable on the next edge. Downstream recovery is its own reset's job.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch x, y, w, h and colour, clear pix_count, and go to CLIP.
- CLIP (1 cycle, cmd_ready=0):
  - Reject condition: x>=H_DISP, or y>=V_DISP, or w==0, or h==0. On reject, pulse cmd_err and go to IDLE.
  - Otherwise w_c = min(w, H_DISP-x) and h_c = min(h, V_DISP-y).
  - Comparisons use 17-bit sums so x+w cannot wrap.
  - row=0, then go to ISSUE.
- ISSUE:
  - xpos=x, ypos=y+row, len={8'd0, w_c}, enable=1.
  - Hold until busy==1 is sampled, then go to RUN.
- RUN:
  - enable=0 on entry.
  - Wait for busy==0.
  - If row==h_c-1, go to DONE; else row<=row+1 and go to GAP.
- GAP (exactly 1 cycle, enable=0):
  - Lets the controller leave its completion state before the next request, then go to ISSUE.
  - Raising enable in the same cycle busy falls is forbidden, because it would hold the controller in completion.
- DONE: pulse done for 1 cycle, then go to IDLE (cmd_ready returns the following cycle).
- sys_write_data:
  - Registered copy of the latched colour, valid from ISSUE of row 0 until the next accept.
  - Unchanged across spans.
- pix_count:
  - Increments on every cycle with sys_write_enable=1 while in ISSUE, RUN or GAP.
  - Saturates at 24'hFFFFFF.
- Simultaneous events:
  - cmd_valid during any non-IDLE state is ignored; cmd_ready=0, so the producer must hold it.
  - busy already high in ISSUE is accepted as the start of the span. The downstream must not be shared.
- Latency:
  - Accept → first enable = 2 cycles (accept edge, CLIP).
  - Last busy fall → done = 1 cycle.

Decomposition:
- Shared package gpu_pkg:
  - State encoding localparams (IDLE, CLIP, ISSUE, RUN, GAP, DONE).
  - Default H_DISP/V_DISP.
  - Coordinate width constant (16).
  - len width constant (24).
- One natural sub-module: gpu_rect_clip.
  - Purely combinational.
  - Inputs: x, y, w, h. Outputs: w_c, h_c, reject.
  - Reused later by the line and blit engines.

Test Plan:
- Reset: rst=1 for 3 cycles mid-RUN → enable=0, cmd_ready=1, done=0, pix_count=0 on the cycle after reset.
- Fill x=10, y=20, w=100, h=3, colour=32'h00FF00FF, with a behavioural controller model → three requests (xpos=10, len=100; ypos=20, 21, 22), each with exactly one GAP cycle; done pulses once; sys_write_data=32'h00FF00FF throughout.
- Clip: x=1000, y=598, w=50, h=10 at 1024x600 → two spans, len=24, ypos=598 and 599.
- Reject: x=1024, then w=0, then y=600 → each gives a single cmd_err pulse, no enable, cmd_ready back within 2 cycles.
- Back-pressure: assert cmd_valid with new values while the first command is in RUN → ignored until IDLE, then accepted with the second command's values.
- Slow controller: busy rises 5 cycles after enable → enable held for all 5 cycles and dropped the cycle after busy is sampled; pix_count equals the number of injected sys_write_enable pulses.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared GPU write-path types and constants
package gpu_pkg;
  localparam int COORD_W = 16;
  localparam int LEN_W = 24;
  localparam int H_DISP_DEF = 1024;
  localparam int V_DISP_DEF = 600;
  typedef enum logic [2:0] {S_IDLE, S_CLIP, S_ISSUE, S_RUN, S_GAP, S_DONE} state_e;
endpackage

// File: rtl/gpu_rect_clip.sv
// gpu_rect_clip: clip a rectangle to the display and flag empty or off-screen rectangles
module gpu_rect_clip import gpu_pkg::*; #(
  parameter int H_DISP = H_DISP_DEF,
  parameter int V_DISP = V_DISP_DEF
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] w_i,
  input  logic [COORD_W-1:0] h_i,
  output logic [COORD_W-1:0] w_c_o,
  output logic [COORD_W-1:0] h_c_o,
  output logic               reject_o
);
  localparam logic [COORD_W:0] HD = (COORD_W+1)'(H_DISP);
  localparam logic [COORD_W:0] VD = (COORD_W+1)'(V_DISP);
  logic [COORD_W:0] x_end, y_end;
  always_comb begin
    x_end = {1'b0, x_i} + {1'b0, w_i};
    y_end = {1'b0, y_i} + {1'b0, h_i};
    reject_o = ({1'b0, x_i} >= HD) || ({1'b0, y_i} >= VD) || (w_i == '0) || (h_i == '0);
    w_c_o = (x_end > HD) ? COORD_W'(HD - {1'b0, x_i}) : w_i;
    h_c_o = (y_end > VD) ? COORD_W'(VD - {1'b0, y_i}) : h_i;
  end
endmodule

// File: rtl/gpu_rect_span_sequencer.sv
// gpu_rect_span_sequencer: clip a rectangle fill and issue it to the span-write controller one row at a time
module gpu_rect_span_sequencer import gpu_pkg::*; #(
  parameter int H_DISP = H_DISP_DEF,
  parameter int V_DISP = V_DISP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [COORD_W-1:0] cmd_w,
  input  logic [COORD_W-1:0] cmd_h,
  input  logic [31:0]        cmd_color,
  output logic [COORD_W-1:0] xpos,
  output logic [COORD_W-1:0] ypos,
  output logic [LEN_W-1:0]   len,
  output logic               enable,
  input  logic               busy,
  input  logic               sys_write_enable,
  output logic [31:0]        sys_write_data,
  output logic               done,
  output logic               cmd_err,
  output logic [LEN_W-1:0]   pix_count
);
  state_e state_q;
  logic [COORD_W-1:0] x_q, y_q, w_q, h_q, hc_q, row_q, w_c, h_c;
  logic [31:0] color_q, data_q;
  logic [COORD_W-1:0] xpos_q, ypos_q;
  logic [LEN_W-1:0] len_q, pix_q, pix_d;
  logic ready_q, enable_q, done_q, err_q, reject;
  gpu_rect_clip #(.H_DISP(H_DISP), .V_DISP(V_DISP)) u_clip (
    .x_i(x_q), .y_i(y_q), .w_i(w_q), .h_i(h_q),
    .w_c_o(w_c), .h_c_o(h_c), .reject_o(reject)
  );
  // strobes are only attributed to the command while a span is in flight
  always_comb
    pix_d = (state_q inside {S_ISSUE, S_RUN, S_GAP}) && sys_write_enable && (pix_q != '1) ? pix_q + LEN_W'(1) : pix_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      enable_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      xpos_q <= '0;
      ypos_q <= '0;
      len_q <= '0;
      data_q <= '0;
      pix_q <= '0;
      row_q <= '0;
      hc_q <= '0;
      x_q <= '0;
      y_q <= '0;
      w_q <= '0;
      h_q <= '0;
      color_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q <= 1'b0;
      pix_q <= pix_d;
      case (state_q)
        S_IDLE: if (cmd_valid) begin
          x_q <= cmd_x;
          y_q <= cmd_y;
          w_q <= cmd_w;
          h_q <= cmd_h;
          color_q <= cmd_color;
          pix_q <= '0;
          ready_q <= 1'b0;
          state_q <= S_CLIP;
        end
        S_CLIP: if (reject) begin
          err_q <= 1'b1;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end else begin
          hc_q <= h_c;
          row_q <= '0;
          xpos_q <= x_q;
          ypos_q <= y_q;
          len_q <= {8'd0, w_c};
          data_q <= color_q;
          enable_q <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: if (busy) begin
          enable_q <= 1'b0;
          state_q <= S_RUN;
        end
        S_RUN: if (!busy) begin
          if (row_q == hc_q - COORD_W'(1)) begin
            done_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            row_q <= row_q + COORD_W'(1);
            state_q <= S_GAP;
          end
        end
        // one idle cycle so the controller can leave its completion state
        S_GAP: begin
          ypos_q <= y_q + row_q;
          enable_q <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign cmd_ready = ready_q;
  assign xpos = xpos_q;
  assign ypos = ypos_q;
  assign len = len_q;
  assign enable = enable_q;
  assign sys_write_data = data_q;
  assign done = done_q;
  assign cmd_err = err_q;
  assign pix_count = pix_q;
endmodule

// File: tb/tb_gpu_rect_span_sequencer.sv
// tb_gpu_rect_span_sequencer: directed checks against a behavioural span-write controller
module tb_gpu_rect_span_sequencer;
  logic clk = 0, rst = 1, cmd_valid = 0, busy = 0, swe = 0;
  logic [15:0] cmd_x = 0, cmd_y = 0, cmd_w = 0, cmd_h = 0;
  logic [31:0] cmd_color = 0;
  logic cmd_ready, enable, done, cmd_err;
  logic [15:0] xpos, ypos;
  logic [23:0] len, pix_count;
  logic [31:0] sys_write_data;
  int checks = 0, errors = 0;
  int mdl_delay = 0, mst = 0, mcnt = 0, mrem = 0, gap_cnt = 0, done_cnt = 0, err_cnt = 0;
  bit gap_arm = 0;
  logic [31:0] exp_color = 0;
  int rq_x[$], rq_y[$], rq_l[$];
  gpu_rect_span_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .xpos(xpos), .ypos(ypos), .len(len), .enable(enable), .busy(busy),
    .sys_write_enable(swe), .sys_write_data(sys_write_data),
    .done(done), .cmd_err(cmd_err), .pix_count(pix_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // controller model: busy rises mdl_delay cycles after a request, one strobe per word, then completes
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (cmd_err) err_cnt++;
    if (rst) begin
      mst = 0; busy = 0; swe = 0; gap_arm = 0;
    end else case (mst)
      0: if (enable) begin
        rq_x.push_back(int'(xpos)); rq_y.push_back(int'(ypos)); rq_l.push_back(int'(len));
        chk("wdata", sys_write_data, exp_color);
        if (gap_arm) chk("gap", gap_cnt, 1);
        gap_arm = 0;
        mcnt = mdl_delay; mrem = int'(len);
        if (mcnt == 0) begin busy = 1; mst = 2; end else mst = 1;
      end else if (gap_arm) begin
        gap_cnt++;
        if (done) gap_arm = 0;
      end
      1: begin
        chk("hold", enable, 1);
        mcnt--;
        if (mcnt == 0) begin busy = 1; mst = 2; end
      end
      default: begin
        chk("drop", enable, 0);
        if (mrem > 0) begin swe = 1; mrem--; end
        else begin swe = 0; busy = 0; gap_arm = 1; gap_cnt = 0; mst = 0; end
      end
    endcase
  end
  task automatic send(input int x, input int y, input int w, input int h, input logic [31:0] c);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk("send_to", cmd_ready, 1);
    cmd_x = 16'(x); cmd_y = 16'(y); cmd_w = 16'(w); cmd_h = 16'(h); cmd_color = c;
    cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    chk("done_to", done, 1);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("ready_back", cmd_ready, 1);
  endtask
  task automatic wait_busy();
    int n = 0;
    while (busy !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk("busy_to", busy, 1);
  endtask
  task automatic chk_req(input int i, input int x, input int y, input int l);
    if (i < rq_x.size()) begin
      chk($sformatf("req%0d_x", i), rq_x[i], x);
      chk($sformatf("req%0d_y", i), rq_y[i], y);
      chk($sformatf("req%0d_len", i), rq_l[i], l);
    end else chk($sformatf("req%0d_missing", i), rq_x.size(), i + 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end
  initial begin
    int d0, e0;
    int rx[3], ry[3], rw[3];
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_enable", enable, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_xpos", xpos, 0);
    chk("rst_ypos", ypos, 0);
    chk("rst_len", len, 0);
    chk("rst_wdata", sys_write_data, 0);
    chk("rst_pix", pix_count, 0);
    rst = 0;
    @(negedge clk);
    // basic fill: three rows
    exp_color = 32'h00FF00FF; d0 = done_cnt;
    send(10, 20, 100, 3, 32'h00FF00FF);
    chk("clip_enable", enable, 0);
    chk("clip_ready", cmd_ready, 0);
    @(negedge clk);
    chk("issue_enable", enable, 1);
    wait_done();
    chk("fill_nreq", rq_x.size(), 3);
    chk_req(0, 10, 20, 100);
    chk_req(1, 10, 21, 100);
    chk_req(2, 10, 22, 100);
    chk("fill_done_cnt", done_cnt - d0, 1);
    chk("fill_pix", pix_count, 300);
    chk("fill_wdata", sys_write_data, 32'h00FF00FF);
    // clipped to the bottom-right corner
    rq_x.delete(); rq_y.delete(); rq_l.delete();
    exp_color = 32'hDEADBEEF; d0 = done_cnt;
    send(1000, 598, 50, 10, 32'hDEADBEEF);
    wait_done();
    chk("clip_nreq", rq_x.size(), 2);
    chk_req(0, 1000, 598, 24);
    chk_req(1, 1000, 599, 24);
    chk("clip_done_cnt", done_cnt - d0, 1);
    chk("clip_pix", pix_count, 48);
    // rejects
    rq_x.delete(); rq_y.delete(); rq_l.delete();
    rx = '{1024, 5, 5}; ry = '{0, 5, 600}; rw = '{4, 0, 4};
    e0 = err_cnt; d0 = done_cnt;
    for (int i = 0; i < 3; i++) begin
      send(rx[i], ry[i], rw[i], 2, 32'h12345678);
      @(negedge clk);
      chk($sformatf("rej%0d_err", i), cmd_err, 1);
      chk($sformatf("rej%0d_ready", i), cmd_ready, 1);
      chk($sformatf("rej%0d_enable", i), enable, 0);
      @(negedge clk);
      chk($sformatf("rej%0d_err_clr", i), cmd_err, 0);
    end
    chk("rej_nreq", rq_x.size(), 0);
    chk("rej_err_cnt", err_cnt - e0, 3);
    chk("rej_done_cnt", done_cnt - d0, 0);
    chk("rej_pix", pix_count, 0);
    // back-pressure: second command held while the first runs
    rq_x.delete(); rq_y.delete(); rq_l.delete();
    exp_color = 32'hA5A5A5A5; d0 = done_cnt;
    send(0, 0, 8, 2, 32'hA5A5A5A5);
    wait_busy();
    cmd_x = 5; cmd_y = 7; cmd_w = 4; cmd_h = 1; cmd_color = 32'h5A5A5A5A;
    cmd_valid = 1;
    begin
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    end
    chk("bp_ready", cmd_ready, 1);
    exp_color = 32'h5A5A5A5A;
    @(negedge clk);
    cmd_valid = 0;
    wait_done();
    chk("bp_nreq", rq_x.size(), 3);
    chk_req(0, 0, 0, 8);
    chk_req(1, 0, 1, 8);
    chk_req(2, 5, 7, 4);
    chk("bp_done_cnt", done_cnt - d0, 2);
    chk("bp_pix", pix_count, 4);
    chk("bp_wdata", sys_write_data, 32'h5A5A5A5A);
    // slow controller
    rq_x.delete(); rq_y.delete(); rq_l.delete();
    mdl_delay = 5; exp_color = 32'h0BADF00D;
    send(100, 100, 6, 2, 32'h0BADF00D);
    wait_done();
    chk("slow_nreq", rq_x.size(), 2);
    chk_req(0, 100, 100, 6);
    chk_req(1, 100, 101, 6);
    chk("slow_pix", pix_count, 12);
    mdl_delay = 0;
    // reset in the middle of a span
    exp_color = 32'h01010101; d0 = done_cnt;
    send(0, 0, 20, 2, 32'h01010101);
    wait_busy();
    repeat (3) @(negedge clk);
    chk("pre_rst_pix_nz", pix_count != 0, 1);
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("mid_rst_enable", enable, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_pix", pix_count, 0);
    chk("mid_rst_wdata", sys_write_data, 0);
    @(negedge clk);
    chk("post_rst_enable", enable, 0);
    chk("post_rst_done_cnt", done_cnt - d0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
